// File: rtl/bcd_count_ctrl_if.sv
// Control/status bundle for bcd_count_ctrl.
// The host drives the master side and bcd_count_ctrl connects to the slave side.
// Optional lap capture signals are present only when BCD_CTRL_LAP_EN is defined.
interface bcd_count_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   limit;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic                  wrap;
`ifdef BCD_CTRL_LAP_EN
  logic                  lap;
  logic [4*DIGITS-1:0]   lap_count;

  modport master (
    output start, stop, clr, load, load_val, limit, lap,
    input  count, running, done, wrap, lap_count
  );
  modport slave (
    input  start, stop, clr, load, load_val, limit, lap,
    output count, running, done, wrap, lap_count
  );
`else
  modport master (
    output start, stop, clr, load, load_val, limit,
    input  count, running, done, wrap
  );
  modport slave (
    input  start, stop, clr, load, load_val, limit,
    output count, running, done, wrap
  );
`endif
endinterface

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: sequencing controller for a cascade of DIGITS decade counters.
// It provides start/stop/clear/load control and a prescaled step with ripple carry.
// Counting stops when the count reaches a BCD terminal value.
// Optional feature: define BCD_CTRL_LAP_EN to add lap capture (lap / lap_count).
module bcd_count_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input logic             clk,
  input logic             rst,
  bcd_count_ctrl_if.slave bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, done_q, wrap_q, wrap_d;
  logic [W-1:0]    inc_val, ld_san;
  logic            inc_all9;
`ifdef BCD_CTRL_LAP_EN
  logic [W-1:0]    lap_q, lap_d;
`endif

  // BCD increment with ripple carry, and the load value with out-of-range nibbles forced to 0
  always_comb begin
    inc_val  = count_q;
    inc_all9 = 1'b1;
    ld_san   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_all9) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_all9          = 1'b0;
        end
      end
      ld_san[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
    end
  end

  // Next state, count and prescaler; priority is clr > load > stop > start
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (bus.load) begin
            count_d = ld_san;
            presc_d = '0;
          end else if (!bus.stop && bus.start) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // load is ignored here; stop freezes the prescaler on the edge it is seen
          if (bus.stop) begin
            state_d = S_PAUSE;
          end else if (presc_q == PMAX) begin
            presc_d = '0;
            count_d = inc_val;
            wrap_d  = inc_all9;
            if (inc_val == bus.limit) state_d = S_DONE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_DONE: begin
          if (bus.load) begin
            count_d = ld_san;
            presc_d = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef BCD_CTRL_LAP_EN
  // Lap capture takes the pre-step count; clr has priority
  always_comb begin
    lap_d = lap_q;
    if (bus.clr) begin
      lap_d = '0;
    end else if (bus.lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
      lap_d = count_q;
    end
  end
`endif

  // State, count, prescaler and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef BCD_CTRL_LAP_EN
      lap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      wrap_q    <= wrap_d;
`ifdef BCD_CTRL_LAP_EN
      lap_q     <= lap_d;
`endif
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.wrap    = wrap_q;
`ifdef BCD_CTRL_LAP_EN
  assign bus.lap_count = lap_q;
`endif

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: vector table, directed corner sequences
// and randomized stimulus against a decimal-arithmetic reference model.
module tb_bcd_count_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bcd_count_ctrl_if #(.DIGITS(2)) ifa ();
  bcd_count_ctrl_if #(.DIGITS(2)) ifb ();
  bcd_count_ctrl_if #(.DIGITS(4)) ifc ();

  bcd_count_ctrl #(.DIGITS(2), .PRESCALE(1))  ua (.clk(clk), .rst(rst), .bus(ifa.slave));
  bcd_count_ctrl #(.DIGITS(2), .PRESCALE(4))  ub (.clk(clk), .rst(rst), .bus(ifb.slave));
  bcd_count_ctrl #(.DIGITS(4), .PRESCALE(10)) uc (.clk(clk), .rst(rst), .bus(ifc.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] i2b(input int v);
    i2b = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int b2i(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int san(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 0 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 0 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  typedef struct {
    logic       st, sp, cl, ld;
    logic [7:0] ldv, lim, cnt;
    logic       run, dn, wr;
  } vec_t;

  function automatic vec_t mk(input logic st, sp, cl, ld, input logic [7:0] ldv, lim, cnt,
                              input logic run, dn, wr);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.ld = ld;
    v.ldv = ldv; v.lim = lim; v.cnt = cnt;
    v.run = run; v.dn = dn; v.wr = wr;
    return v;
  endfunction

  // Reference model for ifb (2 digits, 4 cycles per step), count held as a plain integer
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_cnt, m_ps;
  bit    m_wrap;

  task automatic model_step();
    m_wrap = 1'b0;
    if (ifb.clr) begin
      m_mode = M_IDLE; m_cnt = 0; m_ps = 0;
    end else if (m_mode == M_RUN) begin
      if (ifb.stop) m_mode = M_PAUSE;
      else begin
        m_ps++;
        if (m_ps == 4) begin
          m_ps   = 0;
          m_wrap = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
          if (m_cnt == b2i(ifb.limit)) m_mode = M_DONE;
        end
      end
    end else if (ifb.load) begin
      m_cnt = san(ifb.load_val); m_ps = 0;
      if (m_mode == M_DONE) m_mode = M_IDLE;
    end else if (m_mode != M_DONE && !ifb.stop && ifb.start) begin
      m_mode = M_RUN;
    end
  endtask

  vec_t        tv[17];
  logic [15:0] t16;

  initial begin
    {ifa.start, ifa.stop, ifa.clr, ifa.load, ifa.load_val, ifa.limit} = '0;
    {ifb.start, ifb.stop, ifb.clr, ifb.load, ifb.load_val, ifb.limit} = '0;
    {ifc.start, ifc.stop, ifc.clr, ifc.load, ifc.load_val, ifc.limit} = '0;
`ifdef BCD_CTRL_LAP_EN
    ifa.lap = 1'b0; ifb.lap = 1'b0; ifc.lap = 1'b0;
`endif

    // Reset state
    #12;
    chk("rst_a", {ifa.count, ifa.running, ifa.done, ifa.wrap}, '0);
    chk("rst_b", {ifb.count, ifb.running, ifb.done, ifb.wrap}, '0);
    chk("rst_c", {ifc.count, ifc.running, ifc.done, ifc.wrap}, '0);
`ifdef BCD_CTRL_LAP_EN
    chk("rst_lap", ifa.lap_count, '0);
`endif
    #1 rst = 1'b0;

    // Vector table on ifa (PRESCALE=1)
    tv[0]  = mk(0,0,0,1, 8'hA7, 8'h99, 8'h07, 0,0,0);
    tv[1]  = mk(0,0,0,1, 8'h98, 8'h00, 8'h98, 0,0,0);
    tv[2]  = mk(1,0,0,0, 8'h00, 8'h00, 8'h98, 1,0,0);
    tv[3]  = mk(0,0,0,0, 8'h00, 8'h00, 8'h99, 1,0,0);
    tv[4]  = mk(0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,1);
    tv[5]  = mk(0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,0);
    tv[6]  = mk(1,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,0);
    tv[7]  = mk(0,0,0,1, 8'h00, 8'h00, 8'h00, 0,0,0);
    tv[8]  = mk(1,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0);
    tv[9]  = mk(0,0,0,0, 8'h00, 8'h00, 8'h01, 1,0,0);
    tv[10] = mk(0,0,0,1, 8'h55, 8'h00, 8'h02, 1,0,0);
    tv[11] = mk(1,1,0,0, 8'h00, 8'h00, 8'h02, 0,0,0);
    tv[12] = mk(1,1,0,0, 8'h00, 8'h00, 8'h02, 0,0,0);
    tv[13] = mk(0,0,0,1, 8'h3F, 8'h00, 8'h30, 0,0,0);
    tv[14] = mk(1,0,0,0, 8'h00, 8'h00, 8'h30, 1,0,0);
    tv[15] = mk(0,0,0,0, 8'h00, 8'h00, 8'h31, 1,0,0);
    tv[16] = mk(1,0,1,0, 8'h00, 8'h00, 8'h00, 0,0,0);
    for (int i = 0; i < 17; i++) begin
      ifa.start = tv[i].st; ifa.stop = tv[i].sp; ifa.clr = tv[i].cl; ifa.load = tv[i].ld;
      ifa.load_val = tv[i].ldv; ifa.limit = tv[i].lim;
      tick();
      chk($sformatf("vec%0d", i), {ifa.count, ifa.running, ifa.done, ifa.wrap},
          {tv[i].cnt, tv[i].run, tv[i].dn, tv[i].wr});
    end
    {ifa.start, ifa.stop, ifa.clr, ifa.load, ifa.load_val} = '0;

    // Full count 00..99 with start held, limit 99
    ifa.limit = 8'h99;
    ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
    ifa.start = 1'b1;
    tick();
    chk("seq99_k0", {ifa.count, ifa.running, ifa.done}, {8'h00, 1'b1, 1'b0});
    for (int k = 1; k < 100; k++) begin
      tick();
      t16 = i2b(k);
      chk($sformatf("seq99_k%0d", k), {ifa.count, ifa.running, ifa.done},
          {t16[7:0], k < 99, k == 99});
    end
    repeat (2) begin
      tick();
      chk("seq99_hold", {ifa.count, ifa.running, ifa.done}, {8'h99, 1'b0, 1'b1});
    end
    ifa.start = 1'b0;

    // Pause/resume on ifb (PRESCALE=4)
    ifb.limit = 8'h99;
    ifb.clr = 1'b1; tick(); ifb.clr = 1'b0;
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    chk("pz_run", ifb.running, 1'b1);
    tick(); tick();
    ifb.stop = 1'b1; tick(); ifb.stop = 1'b0;
    chk("pz_paused", {ifb.count, ifb.running, ifb.done}, {8'h00, 1'b0, 1'b0});
    repeat (5) begin
      tick();
      chk("pz_hold", {ifb.count, ifb.running}, {8'h00, 1'b0});
    end
    ifb.stop = 1'b1; ifb.start = 1'b1; tick(); ifb.stop = 1'b0;
    chk("pz_stopwins", ifb.running, 1'b0);
    tick(); ifb.start = 1'b0;
    chk("pz_resume", {ifb.count, ifb.running}, {8'h00, 1'b1});
    tick();
    chk("pz_r1", ifb.count, 8'h00);
    tick();
    chk("pz_r2_step", ifb.count, 8'h01);

    // PRESCALE=10, limit 0003: done on the 30th cycle after start
    ifc.limit = 16'h0003;
    ifc.clr = 1'b1; tick(); ifc.clr = 1'b0;
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("ps10_k%0d", k), {ifc.count, ifc.running, ifc.done},
          {i2b(k / 10), k < 30, k == 30});
    end

    // Randomized run on ifb against the model
    m_mode = M_IDLE; m_cnt = 0; m_ps = 0; m_wrap = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        t16 = i2b($urandom_range(0, 99));
        ifb.limit = ($urandom_range(0, 3) == 0) ? 8'($urandom) : t16[7:0];
      end
      ifb.start    = ($urandom_range(0, 3) == 0);
      ifb.stop     = ($urandom_range(0, 15) == 0);
      ifb.clr      = (c == 0) || ($urandom_range(0, 99) == 0);
      ifb.load     = ($urandom_range(0, 29) == 0);
      ifb.load_val = 8'($urandom);
      @(posedge clk);
      model_step();
      #1;
      t16 = i2b(m_cnt);
      chk($sformatf("rand_c%0d", c), {ifb.count, ifb.running, ifb.done, ifb.wrap},
          {t16[7:0], m_mode == M_RUN, m_mode == M_DONE, m_wrap});
    end
    {ifb.start, ifb.stop, ifb.clr, ifb.load} = '0;

    // Async reset between edges during RUN
    ifa.limit = 8'h99;
    ifa.load = 1'b1; ifa.load_val = 8'h00; tick(); ifa.load = 1'b0;
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    repeat (3) tick();
    chk("ar_pre", {ifa.count, ifa.running}, {8'h03, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("ar_now", {ifa.count, ifa.running, ifa.done}, {8'h00, 1'b0, 1'b0});
    #1 rst = 1'b0;
    tick();
    chk("ar_idle", {ifa.count, ifa.running}, {8'h00, 1'b0});

`ifdef BCD_CTRL_LAP_EN
    // Lap on the same edge as step 05->06 captures 05
    ifa.load = 1'b1; ifa.load_val = 8'h05; tick(); ifa.load = 1'b0;
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    ifa.lap = 1'b1; tick(); ifa.lap = 1'b0;
    chk("lap_cap", {ifa.lap_count, ifa.count}, {8'h05, 8'h06});
    ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
    chk("lap_clr", {ifa.lap_count, ifa.count}, {8'h00, 8'h00});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
